// File: rtl/sched_gen_ctrl_6.sv
// Step-pulse scheduler for a 6-D address generator: fires when the free-running
// cycle counter matches starting_cycle plus the per-dimension cycle offsets.
//   state  | meaning
//   S_IDLE | waiting for start; counters parked
//   S_RUN  | counting cycles and firing on schedule matches
module sched_gen_ctrl_6 #(
    parameter int NUM_DIMS = 6,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clk_en,
    input  logic                      flush,
    input  logic                      start,
    input  logic                      stall,
    input  logic [3:0]                dimensionality,
    input  logic [NUM_DIMS*CNT_W-1:0] ranges,
    input  logic [NUM_DIMS*CNT_W-1:0] cycle_strides,
    input  logic [CNT_W-1:0]          starting_cycle,
    output logic                      step_out,
    output logic                      busy,
    output logic                      done
);
    localparam int DW = $clog2(NUM_DIMS + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]   dim_cnt_q [NUM_DIMS];
    logic [CNT_W-1:0]   dim_cnt_d [NUM_DIMS];
    logic [CNT_W-1:0]   cyc_loc_q [NUM_DIMS];
    logic [CNT_W-1:0]   cyc_loc_d [NUM_DIMS];
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [DW-1:0]       dim_sel;
    logic [CNT_W-1:0]    rng [NUM_DIMS];
    logic [NUM_DIMS-1:0] at_max;
    logic [NUM_DIMS:0]   upd;
    logic [CNT_W-1:0]    sched;
    logic                fire;

    always_comb begin
        dim_sel = (dimensionality > 4'(NUM_DIMS)) ? DW'(NUM_DIMS) : DW'(dimensionality);
    end

    // Odometer carry chain; a zero range counts as a single-trip loop.
    always_comb begin
        sched  = starting_cycle;
        upd    = '0;
        upd[0] = 1'b1;
        at_max = '0;
        for (int i = 0; i < NUM_DIMS; i++) begin
            rng[i] = (ranges[i*CNT_W +: CNT_W] == '0) ? CNT_W'(1) : ranges[i*CNT_W +: CNT_W];
            at_max[i] = (dim_cnt_q[i] == rng[i] - CNT_W'(1));
            upd[i+1]  = upd[i] & at_max[i];
            if (i < int'(dim_sel)) sched = sched + cyc_loc_q[i];
        end
    end

    assign fire = (state_q == S_RUN) & clk_en & ~stall & ~flush & (cycle_cnt_q == sched);

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = done_q;
        cycle_cnt_d = cycle_cnt_q;
        for (int i = 0; i < NUM_DIMS; i++) begin
            dim_cnt_d[i] = dim_cnt_q[i];
            cyc_loc_d[i] = cyc_loc_q[i];
        end
        if (clk_en) begin
            done_d = 1'b0;
            if (flush || (state_q == S_IDLE && start)) begin
                cycle_cnt_d = '0;
                for (int i = 0; i < NUM_DIMS; i++) begin
                    dim_cnt_d[i] = '0;
                    cyc_loc_d[i] = '0;
                end
                state_d = flush ? S_IDLE : S_RUN;
                busy_d  = ~flush;
            end else if (state_q == S_RUN) begin
                if (!stall) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                if (fire) begin
                    for (int i = 0; i < NUM_DIMS; i++) begin
                        if (i < int'(dim_sel) && upd[i]) begin
                            if (at_max[i]) begin
                                dim_cnt_d[i] = '0;
                                cyc_loc_d[i] = '0;
                            end else begin
                                dim_cnt_d[i] = dim_cnt_q[i] + CNT_W'(1);
                                cyc_loc_d[i] = cyc_loc_q[i] + cycle_strides[i*CNT_W +: CNT_W];
                            end
                        end
                    end
                    if (upd[dim_sel]) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cycle_cnt_q <= '0;
            for (int i = 0; i < NUM_DIMS; i++) begin
                dim_cnt_q[i] <= '0;
                cyc_loc_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cycle_cnt_q <= cycle_cnt_d;
            for (int i = 0; i < NUM_DIMS; i++) begin
                dim_cnt_q[i] <= dim_cnt_d[i];
                cyc_loc_q[i] <= cyc_loc_d[i];
            end
        end
    end

    assign step_out = fire;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
